osc_clkgen: RTL and testbench

OSC_CLKGEN -- requirements
Module: osc_clkgen

---
 rtl/osc_clkgen_pkg.sv | 11 +
 rtl/osc_clkgen_ch.sv | 48 ++++
 rtl/osc_clkgen.sv | 65 ++++++
 tb/tb_osc_clkgen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/osc_clkgen_pkg.sv
// osc_clkgen_pkg: control state encoding and default parameters for osc_clkgen
package osc_clkgen_pkg;
    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_SYNC = 2'd1,
        S_RUN  = 2'd2
    } state_t;
    localparam int NCH_DEF         = 4;
    localparam int DIVW_DEF        = 16;
    localparam int STARTUP_CYC_DEF = 1024;
endpackage

// File: rtl/osc_clkgen_ch.sv
// osc_clkgen_ch: one divided-clock channel (shadow divide, counter, CE/CLKOUT, enable gating)
module osc_clkgen_ch
    import osc_clkgen_pkg::*;
#(
    parameter int DIVW = DIVW_DEF
) (
    input  logic            CLK,
    input  logic            RESETN,
    input  logic            i_sync,
    input  logic            i_run,
    input  logic            i_en,
    input  logic [DIVW-1:0] i_div,
    input  logic [DIVW-1:0] i_phase,
    output logic            o_ce,
    output logic            o_clk
);
    logic [DIVW-1:0] r_div, r_cnt, w_pre;
    logic [DIVW:0]   w_half;
    logic            r_act, r_ce, r_clk, w_wrap, w_idle;

    assign w_pre  = (i_phase > i_div) ? '0 : i_phase;
    assign w_wrap = r_cnt == r_div;
    assign w_idle = !r_act || w_wrap;
    assign w_half = ({1'b0, r_div} + (DIVW+1)'(1)) >> 1;
    assign o_ce   = r_ce;
    assign o_clk  = r_clk;

    // an inactive channel parks at 0; enable changes are only honoured there or at the wrap
    always_ff @(posedge CLK or negedge RESETN)
        if (!RESETN) begin
            r_div <= '0;
            r_cnt <= '0;
            r_act <= 1'b0;
            r_ce  <= 1'b0;
            r_clk <= 1'b0;
        end else if (i_sync) begin
            r_div <= i_div;
            r_cnt <= i_en ? w_pre : '0;
            r_act <= i_en;
            r_ce  <= 1'b0;
            r_clk <= 1'b0;
        end else if (i_run) begin
            r_ce  <= r_act && w_wrap;
            r_clk <= r_act && ({1'b0, r_cnt} < w_half);
            r_cnt <= w_idle ? '0 : r_cnt + DIVW'(1);
            r_act <= w_idle ? i_en : 1'b1;
        end
endmodule

// File: rtl/osc_clkgen.sv
// osc_clkgen: startup-gated multi-channel clock divider for the fabric RC oscillator.
// Define OSC_CLKGEN_PHASE_EN to add the PHASE port presetting each channel counter at SYNC.
module osc_clkgen
    import osc_clkgen_pkg::*;
#(
    parameter int NCH         = NCH_DEF,
    parameter int DIVW        = DIVW_DEF,
    parameter int STARTUP_CYC = STARTUP_CYC_DEF
) (
    input  logic                CLK,
    input  logic                RESETN,
    input  logic [NCH*DIVW-1:0] DIV,
`ifdef OSC_CLKGEN_PHASE_EN
    input  logic [NCH*DIVW-1:0] PHASE,
`endif
    input  logic [NCH-1:0]      CH_EN,
    input  logic                LOAD,
    output logic [NCH-1:0]      CE,
    output logic [NCH-1:0]      CLKOUT,
    output logic                READY
);
    localparam int WCW = $clog2(STARTUP_CYC + 1);

    state_t         r_state;
    logic [WCW-1:0] r_wcnt;
    logic           r_ready, w_wdone, w_sync, w_run;

    assign w_wdone = r_wcnt == WCW'(STARTUP_CYC - 1);
    assign w_sync  = (r_state == S_WAIT && w_wdone) || (r_state == S_RUN && LOAD);
    assign w_run   = r_state != S_WAIT;
    assign READY   = r_ready;

    // w_sync marks the edge into SYNC, so outputs are already cleared during the SYNC cycle
    always_ff @(posedge CLK or negedge RESETN)
        if (!RESETN) begin
            r_state <= S_WAIT;
            r_wcnt  <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_sync ? S_SYNC : (r_state == S_WAIT ? S_WAIT : S_RUN);
            r_wcnt  <= (r_state == S_WAIT && !w_wdone) ? r_wcnt + WCW'(1) : r_wcnt;
            if (r_state == S_SYNC)
                r_ready <= 1'b1;
        end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [DIVW-1:0] w_phase;
`ifdef OSC_CLKGEN_PHASE_EN
        assign w_phase = PHASE[i*DIVW +: DIVW];
`else
        assign w_phase = '0;
`endif
        osc_clkgen_ch #(.DIVW(DIVW)) u_ch (
            .CLK     (CLK),
            .RESETN  (RESETN),
            .i_sync  (w_sync),
            .i_run   (w_run),
            .i_en    (CH_EN[i]),
            .i_div   (DIV[i*DIVW +: DIVW]),
            .i_phase (w_phase),
            .o_ce    (CE[i]),
            .o_clk   (CLKOUT[i])
        );
    end
endmodule

// File: tb/tb_osc_clkgen.sv
// tb_osc_clkgen: randomized bench for osc_clkgen against a period/origin reference model
module tb_osc_clkgen;
    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int SC  = 16;

    logic              CLK, RESETN, LOAD, READY;
    logic [NCH*DW-1:0] DIV;
    logic [NCH-1:0]    CH_EN, CE, CLKOUT;
`ifdef OSC_CLKGEN_PHASE_EN
    logic [NCH*DW-1:0] PHASE;
`endif

    osc_clkgen #(.NCH(NCH), .DIVW(DW), .STARTUP_CYC(SC)) dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .DIV    (DIV),
`ifdef OSC_CLKGEN_PHASE_EN
        .PHASE  (PHASE),
`endif
        .CH_EN  (CH_EN),
        .LOAD   (LOAD),
        .CE     (CE),
        .CLKOUT (CLKOUT),
        .READY  (READY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk = 0, n_pass = 0;
    int cyc, m_sync, rdy_at;
    int m_o[NCH], m_div[NCH];
    bit m_act[NCH];
    logic [NCH-1:0] e_ce, e_clk;
    logic e_rdy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        else n_pass++;
    endtask

    task automatic model_reset();
        cyc = 0;
        m_sync = SC;
        rdy_at = -1;
        e_ce = '0;
        e_clk = '0;
        e_rdy = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            m_act[i] = 0;
            m_o[i] = 0;
            m_div[i] = 0;
        end
    endtask

    // channel i, active since origin o, has CE in cycles o+k*(DIV+1) and CLKOUT high for the first (DIV+1)/2 cycles of each period
    task automatic model_step();
        logic [NCH-1:0] nce, nclk;
        bit sy;
        int p, pos, ph;
        sy = (cyc == SC - 1) || (cyc > m_sync && LOAD);
        for (int i = 0; i < NCH; i++) begin
            p = m_div[i] + 1;
            pos = m_act[i] ? (cyc - m_o[i]) % p : 0;
            nce[i] = m_act[i] && pos == m_div[i];
            nclk[i] = m_act[i] && pos < p / 2;
            if (m_act[i] && pos == m_div[i] && !CH_EN[i]) m_act[i] = 0;
            else if (!m_act[i] && CH_EN[i] && cyc >= m_sync) begin
                m_act[i] = 1;
                m_o[i] = cyc + 1;
            end
            if (sy) begin
                m_div[i] = int'(DIV[i*DW +: DW]);
                ph = 0;
`ifdef OSC_CLKGEN_PHASE_EN
                ph = int'(PHASE[i*DW +: DW]);
                if (ph > m_div[i]) ph = 0;
`endif
                m_act[i] = CH_EN[i];
                m_o[i] = cyc + 1 - ph;
            end
        end
        e_rdy = e_rdy || (cyc == m_sync);
        if (sy) begin
            nce = '0;
            nclk = '0;
            m_sync = cyc + 1;
        end
        e_ce = nce;
        e_clk = nclk;
    endtask

    task automatic step();
        model_step();
        @(posedge CLK);
        #1;
        cyc++;
        check("ce", 32'(CE), 32'(e_ce));
        check("clkout", 32'(CLKOUT), 32'(e_clk));
        check("ready", 32'(READY), 32'(e_rdy));
        if (READY && rdy_at < 0) rdy_at = cyc;
    endtask

    initial begin
        int j;
        RESETN = 1'b0;
        LOAD = 1'b0;
        CH_EN = '1;
        DIV = {8'd7, 8'd0, 8'd4, 8'd3};
`ifdef OSC_CLKGEN_PHASE_EN
        PHASE = '0;
`endif
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ce", 32'(CE), 32'd0);
        check("rst_clkout", 32'(CLKOUT), 32'd0);
        check("rst_ready", 32'(READY), 32'd0);
        RESETN = 1'b1;
        repeat (5) step();
        LOAD = 1'b1;
        step();
        LOAD = 1'b0;
        repeat (40) step();
        check("ready_rise", 32'(rdy_at), 32'(SC + 1));

        DIV[2*DW +: DW] = 8'd9;
        LOAD = 1'b1;
        step();
        step();
        LOAD = 1'b0;
        repeat (30) step();

        LOAD = 1'b1;
        step();
        LOAD = 1'b0;
        step();
        step();
        CH_EN[3] = 1'b0;
        repeat (20) step();
        check("ch3_off_clk", 32'(CLKOUT[3]), 32'd0);
        CH_EN[3] = 1'b1;
        repeat (20) step();

`ifdef OSC_CLKGEN_PHASE_EN
        DIV = {8'd7, 8'd7, 8'd7, 8'd7};
        PHASE = {8'd0, 8'd9, 8'd4, 8'd0};
        LOAD = 1'b1;
        step();
        LOAD = 1'b0;
        repeat (30) step();
`endif

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 15) == 0) begin
                j = $urandom_range(0, NCH - 1);
                CH_EN[j] = ~CH_EN[j];
            end
            if ($urandom_range(0, 7) == 0) begin
                j = $urandom_range(0, NCH - 1);
                DIV[j*DW +: DW] = DW'($urandom_range(0, 11));
            end
`ifdef OSC_CLKGEN_PHASE_EN
            if ($urandom_range(0, 7) == 0) begin
                j = $urandom_range(0, NCH - 1);
                PHASE[j*DW +: DW] = DW'($urandom_range(0, 12));
            end
`endif
            LOAD = $urandom_range(0, 24) == 0;
            step();
        end
        LOAD = 1'b0;

        DIV = {8'd7, 8'd9, 8'd4, 8'd3};
        CH_EN = '1;
        LOAD = 1'b1;
        step();
        LOAD = 1'b0;
        repeat (6) step();
        #3;
        RESETN = 1'b0;
        #1;
        check("arst_ce", 32'(CE), 32'd0);
        check("arst_clkout", 32'(CLKOUT), 32'd0);
        check("arst_ready", 32'(READY), 32'd0);
        @(posedge CLK);
        #1;
        RESETN = 1'b1;
        model_reset();
        repeat (40) step();
        check("ready_rise2", 32'(rdy_at), 32'(SC + 1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
